// File: rtl/rvant_decode_stage.sv
// rvant_decode_pkg / rvant_decode_stage
//
// Decode stage between fetch and execute. Raw RV32I/M instruction words are
// decoded combinationally into register addresses, immediate, opcode class
// and legality. The decoded fields are registered into a two-entry
// OUT/SKID buffer so that instr_ready_o can be a flop while full throughput
// is kept.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   flush_i                     drop both buffered entries
//   instr_valid_i/ready_o       fetch-side handshake
//   instr_rdata_i, instr_pc_i   instruction word and its PC
//   dec_valid_o/dec_ready_i     execute-side handshake
//   dec_pc_o, dec_opcode_o,
//   dec_funct3_o, dec_funct7_o  raw instruction fields
//   rs1_addr_o, rs2_addr_o,
//   rd_addr_o, rd_we_o          register addresses and rd write enable
//   imm_o                       sign-extended immediate
//   illegal_insn_o              instruction is illegal

package rvant_decode_pkg;

  typedef enum logic [1:0] {
    RV32MNone = 2'd0,
    RV32MSlow = 2'd1,
    RV32MFast = 2'd2
  } rv32m_e;

  typedef enum logic [6:0] {
    OPCODE_LOAD     = 7'h03,
    OPCODE_MISC_MEM = 7'h0f,
    OPCODE_OP_IMM   = 7'h13,
    OPCODE_AUIPC    = 7'h17,
    OPCODE_STORE    = 7'h23,
    OPCODE_OP       = 7'h33,
    OPCODE_LUI      = 7'h37,
    OPCODE_BRANCH   = 7'h63,
    OPCODE_JALR     = 7'h67,
    OPCODE_JAL      = 7'h6f,
    OPCODE_SYSTEM   = 7'h73
  } opcode_e;

endpackage

module rvant_decode_stage
  import rvant_decode_pkg::*;
#(
  parameter rv32m_e RV32M = RV32MNone
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_rdata_i,
  input  logic [31:0] instr_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_pc_o,
  output logic [6:0]  dec_opcode_o,
  output logic [2:0]  dec_funct3_o,
  output logic [6:0]  dec_funct7_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o,
  output logic [31:0] imm_o,
  output logic        illegal_insn_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  dec_t dec_d;
  dec_t out_q;
  dec_t skid_q;
  logic out_valid_q;
  logic skid_valid_q;
  logic ready_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] instr;
  logic       writes_rd;
  logic       illegal;
  logic [31:0] imm;

  assign instr  = instr_rdata_i;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  always_comb begin
    illegal   = 1'b0;
    imm       = '0;
    writes_rd = 1'b0;

    case (opcode)
      OPCODE_LOAD: begin
        imm       = {{20{instr[31]}}, instr[31:20]};
        writes_rd = 1'b1;
        illegal   = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPCODE_STORE: begin
        imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        illegal = (funct3 > 3'd2);
      end
      OPCODE_BRANCH: begin
        imm     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPCODE_JALR: begin
        imm       = {{20{instr[31]}}, instr[31:20]};
        writes_rd = 1'b1;
        illegal   = (funct3 != 3'd0);
      end
      OPCODE_JAL: begin
        imm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        imm       = {instr[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OPCODE_OP_IMM: begin
        imm       = {{20{instr[31]}}, instr[31:20]};
        writes_rd = 1'b1;
        if (funct3 == 3'd1) begin
          illegal = (funct7 != 7'h00);
        end else if (funct3 == 3'd5) begin
          illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
      end
      OPCODE_OP: begin
        writes_rd = 1'b1;
        if ((funct7 != 7'h00) && (funct7 != 7'h01) && (funct7 != 7'h20)) begin
          illegal = 1'b1;
        end else if ((funct7 == 7'h20) && (funct3 != 3'd0) && (funct3 != 3'd5)) begin
          illegal = 1'b1;
        end else if ((funct7 == 7'h01) && (RV32M == RV32MNone)) begin
          illegal = 1'b1;
        end
      end
      OPCODE_MISC_MEM: begin
        illegal = (funct3 > 3'd1);
      end
      OPCODE_SYSTEM: begin
        imm       = {{20{instr[31]}}, instr[31:20]};
        writes_rd = (funct3 != 3'd0);
        illegal   = (funct3 == 3'd4);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end

    dec_d         = '0;
    dec_d.pc      = instr_pc_i;
    dec_d.opcode  = opcode;
    dec_d.funct3  = funct3;
    dec_d.funct7  = funct7;
    dec_d.rs1     = instr[19:15];
    dec_d.rs2     = instr[24:20];
    dec_d.rd      = instr[11:7];
    dec_d.imm     = imm;
    dec_d.illegal = illegal;
    dec_d.rd_we   = writes_rd && !illegal && (instr[11:7] != 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Two-entry skid buffer
  // ---------------------------------------------------------------------------
  logic accept;
  logic consume;

  assign accept  = instr_valid_i && ready_q;
  assign consume = out_valid_q && dec_ready_i;

  // SKID only fills while OUT is held, so ready_q == !skid_valid_q at all
  // times outside reset; it is computed from the next SKID state to stay a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (skid_valid_q) begin
      if (consume) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else begin
        ready_q      <= 1'b0;
      end
    end else begin
      if (accept) begin
        if (!out_valid_q || consume) begin
          out_q       <= dec_d;
          out_valid_q <= 1'b1;
          ready_q     <= 1'b1;
        end else begin
          skid_q       <= dec_d;
          skid_valid_q <= 1'b1;
          ready_q      <= 1'b0;
        end
      end else begin
        if (consume) begin
          out_valid_q <= 1'b0;
        end
        ready_q <= 1'b1;
      end
    end
  end

  assign instr_ready_o  = ready_q;
  assign dec_valid_o    = out_valid_q;
  assign dec_pc_o       = out_q.pc;
  assign dec_opcode_o   = out_q.opcode;
  assign dec_funct3_o   = out_q.funct3;
  assign dec_funct7_o   = out_q.funct7;
  assign rs1_addr_o     = out_q.rs1;
  assign rs2_addr_o     = out_q.rs2;
  assign rd_addr_o      = out_q.rd;
  assign rd_we_o        = out_q.rd_we;
  assign imm_o          = out_q.imm;
  assign illegal_insn_o = out_q.illegal;

endmodule

// File: tb/tb_rvant_decode_stage.sv
// Self-checking bench for rvant_decode_stage. Two instances share all inputs:
// one with the M extension (RV32MFast), one without (RV32MNone). A queue of
// accepted instructions models buffer occupancy; expected decode results are
// computed from the instruction word with plain arithmetic.
module tb_rvant_decode_stage;
  import rvant_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        instr_valid_i;
  logic [31:0] instr_rdata_i;
  logic [31:0] instr_pc_i;
  logic        dec_ready_i;

  logic        f_ready, f_valid, f_we, f_ill;
  logic [31:0] f_pc, f_imm;
  logic [6:0]  f_op, f_f7;
  logic [2:0]  f_f3;
  logic [4:0]  f_rs1, f_rs2, f_rd;

  logic        n_ready, n_valid, n_we, n_ill;
  logic [31:0] n_pc, n_imm;
  logic [6:0]  n_op, n_f7;
  logic [2:0]  n_f3;
  logic [4:0]  n_rs1, n_rs2, n_rd;

  always #5 clk = ~clk;

  rvant_decode_stage #(.RV32M(RV32MFast)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(f_ready),
    .instr_rdata_i(instr_rdata_i), .instr_pc_i(instr_pc_i),
    .dec_valid_o(f_valid), .dec_ready_i(dec_ready_i), .dec_pc_o(f_pc),
    .dec_opcode_o(f_op), .dec_funct3_o(f_f3), .dec_funct7_o(f_f7),
    .rs1_addr_o(f_rs1), .rs2_addr_o(f_rs2), .rd_addr_o(f_rd),
    .rd_we_o(f_we), .imm_o(f_imm), .illegal_insn_o(f_ill)
  );

  rvant_decode_stage #(.RV32M(RV32MNone)) dut_n (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(n_ready),
    .instr_rdata_i(instr_rdata_i), .instr_pc_i(instr_pc_i),
    .dec_valid_o(n_valid), .dec_ready_i(dec_ready_i), .dec_pc_o(n_pc),
    .dec_opcode_o(n_op), .dec_funct3_o(n_f3), .dec_funct7_o(n_f7),
    .rs1_addr_o(n_rs1), .rs2_addr_o(n_rs2), .rd_addr_o(n_rd),
    .rd_we_o(n_we), .imm_o(n_imm), .illegal_insn_o(n_ill)
  );

  typedef struct { logic [31:0] w; logic [31:0] pc; } item_t;
  typedef struct { logic [31:0] imm; logic ill; logic we; } rexp_t;

  item_t q[$];
  bit    mready;
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic rexp_t ref_dec(input logic [31:0] w, input bit has_m);
    rexp_t r;
    int f3 = int'(w[14:12]);
    int f7 = int'(w[31:25]);
    bit wr = 0;
    r.imm = 0;
    r.ill = 0;
    case (int'(w[6:0]))
      'h03: begin r.imm = 32'($signed(w) >>> 20); wr = 1; r.ill = (f3 == 3 || f3 == 6 || f3 == 7); end
      'h23: begin r.imm = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]); r.ill = (f3 > 2); end
      'h63: begin
        r.imm = (32'($signed(w) >>> 31) << 12) | (32'(w[7]) << 11) |
                (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        r.ill = (f3 == 2 || f3 == 3);
      end
      'h67: begin r.imm = 32'($signed(w) >>> 20); wr = 1; r.ill = (f3 != 0); end
      'h6f: begin
        r.imm = (32'($signed(w) >>> 31) << 20) | (32'(w[19:12]) << 12) |
                (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        wr = 1;
      end
      'h37, 'h17: begin r.imm = w & 32'hFFFF_F000; wr = 1; end
      'h13: begin
        r.imm = 32'($signed(w) >>> 20); wr = 1;
        if (f3 == 1) r.ill = (f7 != 0);
        if (f3 == 5) r.ill = !(f7 == 0 || f7 == 'h20);
      end
      'h33: begin
        wr = 1;
        r.ill = !(f7 == 0 || f7 == 1 || f7 == 'h20) ||
                (f7 == 'h20 && !(f3 == 0 || f3 == 5)) ||
                (f7 == 1 && !has_m);
      end
      'h0f: r.ill = (f3 > 1);
      'h73: begin r.imm = 32'($signed(w) >>> 20); wr = (f3 != 0); r.ill = (f3 == 4); end
      default: r.ill = 1;
    endcase
    r.we = wr && !r.ill && (w[11:7] != 0);
    return r;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [6:0] ops [11] = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h23, 7'h33,
                             7'h37, 7'h63, 7'h67, 7'h6f, 7'h73};
    logic [31:0] w = $urandom();
    int k = int'($urandom_range(0, 13));
    if (k < 11) w[6:0] = ops[k];
    else if (k == 11) w[1:0] = 2'($urandom_range(0, 2));
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h01;
      2: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_all();
    rexp_t ef, en;
    chk("valid",   32'(f_valid), 32'(q.size() > 0));
    chk("ready",   32'(f_ready), 32'(mready && q.size() < 2));
    chk("valid_n", 32'(n_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      ef = ref_dec(q[0].w, 1'b1);
      en = ref_dec(q[0].w, 1'b0);
      chk("pc",     f_pc, q[0].pc);
      chk("opcode", 32'(f_op),  32'(q[0].w[6:0]));
      chk("funct3", 32'(f_f3),  32'(q[0].w[14:12]));
      chk("funct7", 32'(f_f7),  32'(q[0].w[31:25]));
      chk("rs1",    32'(f_rs1), 32'(q[0].w[19:15]));
      chk("rs2",    32'(f_rs2), 32'(q[0].w[24:20]));
      chk("rd",     32'(f_rd),  32'(q[0].w[11:7]));
      chk("imm",    f_imm, ef.imm);
      chk("illegal", 32'(f_ill), 32'(ef.ill));
      chk("rd_we",  32'(f_we),  32'(ef.we));
      chk("illegal_n", 32'(n_ill), 32'(en.ill));
      chk("rd_we_n",   32'(n_we),  32'(en.we));
    end
  endtask

  // Entered at a negedge; drives inputs, models the posedge, checks at next negedge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bit acc, cons;
    item_t it;
    instr_valid_i = v;
    instr_rdata_i = w;
    instr_pc_i    = pc;
    dec_ready_i   = rdy;
    flush_i       = fl;
    acc  = v && mready && (q.size() < 2);
    cons = (q.size() > 0) && rdy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) begin it.w = w; it.pc = pc; q.push_back(it); end
    end
    mready = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; instr_valid_i = 1'b0;
    instr_rdata_i = '0; instr_pc_i = '0; dec_ready_i = 1'b0;
    mready = 1'b0;
    #1;
    check_all();
    chk("reset_pc", f_pc, 32'h0);
    chk("reset_imm", f_imm, 32'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // ADDI x1, x0, 5
    cycle(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    chk("addi_valid", 32'(f_valid), 32'd1);
    chk("addi_rd", 32'(f_rd), 32'd1);
    chk("addi_imm", f_imm, 32'h5);
    chk("addi_we", 32'(f_we), 32'd1);
    chk("addi_pc", f_pc, 32'h100);
    // BEQ with negative offset
    cycle(1'b1, 32'hFE00_0EE3, 32'h104, 1'b1, 1'b0);
    chk("beq_imm", f_imm, 32'hFFFF_FFFC);
    chk("beq_op", 32'(f_op), 32'h63);
    chk("beq_we", 32'(f_we), 32'd0);
    // MUL x2, x1, x2
    cycle(1'b1, 32'h0220_8133, 32'h108, 1'b1, 1'b0);
    chk("mul_ill_fast", 32'(f_ill), 32'd0);
    chk("mul_we_fast", 32'(f_we), 32'd1);
    chk("mul_ill_none", 32'(n_ill), 32'd1);
    chk("mul_we_none", 32'(n_we), 32'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: A, B, C offered with execute stalled for 3 cycles
    cycle(1'b1, 32'h0010_0113, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0193, 32'h204, 1'b0, 1'b0);
    cycle(1'b1, 32'h0030_0213, 32'h208, 1'b0, 1'b0);
    chk("bp_ready_low", 32'(f_ready), 32'd0);
    chk("bp_head_pc", f_pc, 32'h200);
    cycle(1'b1, 32'h0030_0213, 32'h208, 1'b1, 1'b0);
    chk("bp_second_pc", f_pc, 32'h204);
    cycle(1'b1, 32'h0030_0213, 32'h208, 1'b1, 1'b0);
    chk("bp_third_pc", f_pc, 32'h208);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with both entries valid and a new offer in the flush cycle
    cycle(1'b1, 32'h0040_0293, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h0050_0313, 32'h304, 1'b0, 1'b0);
    cycle(1'b1, 32'h0060_0393, 32'h308, 1'b0, 1'b1);
    chk("flush_valid", 32'(f_valid), 32'd0);
    chk("flush_ready", 32'(f_ready), 32'd1);
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), rnd_word(), $urandom() & 32'hFFFF_FFFC,
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0));
    end

    // Reset mid-stream: outputs clear with no clock edge
    cycle(1'b1, 32'h0070_0413, 32'h400, 1'b0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid", 32'(f_valid), 32'd0);
    chk("rst_ready", 32'(f_ready), 32'd0);
    chk("rst_pc", f_pc, 32'h0);
    chk("rst_imm", f_imm, 32'h0);
    chk("rst_rd", 32'(f_rd), 32'd0);
    q.delete();
    mready = 1'b0;
    @(negedge clk);
    check_all();
    rst_ni = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0000, 32'h500, 1'b1, 1'b0);
    chk("zero_valid", 32'(f_valid), 32'd1);
    chk("zero_illegal", 32'(f_ill), 32'd1);
    chk("zero_we", 32'(f_we), 32'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
